// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART peripheral register front-end:
//   - byte offsets of the registers inside the 16-byte window
//   - CTRL and STATUS bit positions
//   - default reset value of the baud divisor
// -----------------------------------------------------------------------------
package uart_pkg;

  // Register byte offsets inside the decoded window
  localparam logic [3:0] OFF_CTRL   = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h2;
  localparam logic [3:0] OFF_BAUD   = 4'h4;
  localparam logic [3:0] OFF_TXDATA = 4'h6;
  localparam logic [3:0] OFF_RXDATA = 4'h8;

  // CTRL bit positions
  localparam int CTRL_EN   = 0;
  localparam int CTRL_RXIE = 1;
  localparam int CTRL_TXIE = 2;

  // STATUS bit positions
  localparam int ST_RX_AVAIL = 0;
  localparam int ST_TX_BUSY  = 1;
  localparam int ST_TX_PEND  = 2;
  localparam int ST_RX_OVF   = 3;
  localparam int ST_RX_LVL   = 4;  // bits 6:4

  // Baud divisor after reset
  localparam logic [15:0] BAUD_RST_DEF = 16'd5208;

  typedef struct packed {
    logic txie;
    logic rxie;
    logic en;
  } ctrl_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Small circular receive queue of DEPTH bytes (DEPTH <= 7).
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   i_push     : store i_din; accepted when not full, or when full and a pop
//                happens in the same cycle
//   i_din      : byte to store
//   i_pop      : drop the head entry (ignored when empty)
//   o_dout     : head entry, 0 when empty
//   o_full     : DEPTH entries held
//   o_empty    : no entries held
//   o_level    : number of entries held
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_din,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_dout,
  output logic              o_full,
  output logic              o_empty,
  output logic [2:0]        o_level
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [2:0]        r_cnt;
  logic              w_push;
  logic              w_pop;

  // Wraps at DEPTH so non-power-of-two depths (including 1) stay in range
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    else                     return p + 1'b1;
  endfunction

  assign o_full  = (r_cnt == 3'(DEPTH));
  assign o_empty = (r_cnt == 3'd0);
  assign o_level = r_cnt;

  assign w_pop  = i_pop & ~o_empty;
  // When full, a simultaneous pop frees the slot the push writes into
  assign w_push = i_push & (~o_full | w_pop);

  assign o_dout = o_empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= next_ptr(r_wptr);
      if (w_pop)  r_rptr <= next_ptr(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 3'd1;
        2'b01:   r_cnt <= r_cnt - 3'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/uart_per_regs.sv
// -----------------------------------------------------------------------------
// uart_per_regs
// Memory-mapped register front-end between the openMSP430 peripheral bus and
// the UART core. Decodes a 16-byte window holding CTRL, STATUS, BAUD, TXDATA
// and RXDATA; buffers one transmit byte; queues received bytes; drives a level
// interrupt.
//
// Build option:
//   UART_RX_FIFO_EN  defined   -> 4-entry receive FIFO
//                    undefined -> single receive holding register
//
// Ports:
//   mclk, puc_rst      : clock, asynchronous active-high reset
//   per_addr/per_din   : peripheral word address / write data
//   per_en/per_we      : access enable / byte write enables
//   per_dout           : read data, 0 when not selected
//   tx_data/tx_start   : byte and one-cycle launch pulse to the transmitter
//   tx_busy            : transmitter busy
//   rx_data/rx_valid   : received byte and its one-cycle valid pulse
//   baud_div           : divisor to the speed-select instances
//   irq                : level interrupt
// -----------------------------------------------------------------------------
module uart_per_regs
  import uart_pkg::*;
#(
  parameter logic [14:0] BASE_ADDR = 15'h0080,
  parameter int          DEC_WD    = 4,
  parameter logic [15:0] BAUD_RST  = BAUD_RST_DEF
) (
  input  logic        mclk,
  input  logic        puc_rst,
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  output logic [15:0] per_dout,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [15:0] baud_div,
  output logic        irq
);

`ifdef UART_RX_FIFO_EN
  localparam int RX_DEPTH = 4;
`else
  localparam int RX_DEPTH = 1;
`endif

  ctrl_t       r_ctrl;
  logic [15:0] r_baud;
  logic [7:0]  r_tx_hold;
  logic        r_tx_pend;
  logic        r_rx_ovf;

  logic              w_sel;
  logic [DEC_WD-1:0] w_off;
  logic              w_we_lo;
  logic              w_we_hi;
  logic              w_rd;
  logic              w_tx_load;
  logic              w_launch;
  logic              w_rx_push;
  logic              w_rx_pop;
  logic              w_rx_full;
  logic              w_rx_empty;
  logic [2:0]        w_rx_level;
  logic [7:0]        w_rx_dout;
  logic              w_ovf_set;
  logic              w_ovf_clr;
  logic [15:0]       w_status;
  logic [15:0]       w_rdata;

  // Address decode
  assign w_sel   = per_en & (per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
  assign w_off   = {per_addr[DEC_WD-2:0], 1'b0};
  assign w_we_lo = w_sel & per_we[0];
  assign w_we_hi = w_sel & per_we[1];
  assign w_rd    = w_sel & (per_we == 2'b00);

  // Transmit path: a load is only accepted while nothing is pending, so it
  // can never coincide with a launch
  assign w_tx_load = w_we_lo & (w_off == DEC_WD'(OFF_TXDATA)) & ~r_tx_pend;
  assign w_launch  = r_ctrl.en & r_tx_pend & ~tx_busy;
  assign tx_start  = w_launch;
  assign tx_data   = r_tx_hold;

  // Receive path
  assign w_rx_push = r_ctrl.en & rx_valid;
  assign w_rx_pop  = w_rd & (w_off == DEC_WD'(OFF_RXDATA)) & ~w_rx_empty;
  // A pop in the same cycle makes room, so overflow only when nothing leaves
  assign w_ovf_set = w_rx_push & w_rx_full & ~w_rx_pop;
  assign w_ovf_clr = w_we_lo & (w_off == DEC_WD'(OFF_STATUS)) & per_din[ST_RX_OVF];

  uart_rx_fifo #(
    .DEPTH  (RX_DEPTH),
    .DATA_W (8)
  ) u_rx_fifo (
    .clk     (mclk),
    .rst     (puc_rst),
    .i_push  (w_rx_push),
    .i_din   (rx_data),
    .i_pop   (w_rx_pop),
    .o_dout  (w_rx_dout),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty),
    .o_level (w_rx_level)
  );

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      r_ctrl    <= '0;
      r_baud    <= BAUD_RST;
      r_tx_hold <= '0;
      r_tx_pend <= 1'b0;
      r_rx_ovf  <= 1'b0;
    end else begin
      if (w_we_lo && (w_off == DEC_WD'(OFF_CTRL))) begin
        r_ctrl.en   <= per_din[CTRL_EN];
        r_ctrl.rxie <= per_din[CTRL_RXIE];
        r_ctrl.txie <= per_din[CTRL_TXIE];
      end
      if (w_we_lo && (w_off == DEC_WD'(OFF_BAUD))) r_baud[7:0]  <= per_din[7:0];
      if (w_we_hi && (w_off == DEC_WD'(OFF_BAUD))) r_baud[15:8] <= per_din[15:8];
      if (w_tx_load) r_tx_hold <= per_din[7:0];
      if (w_tx_load)     r_tx_pend <= 1'b1;
      else if (w_launch) r_tx_pend <= 1'b0;
      // A new overflow wins over a clear in the same cycle
      if (w_ovf_set)      r_rx_ovf <= 1'b1;
      else if (w_ovf_clr) r_rx_ovf <= 1'b0;
    end
  end

  assign baud_div = r_baud;

  always_comb begin
    w_status                          = '0;
    w_status[ST_RX_AVAIL]             = ~w_rx_empty;
    w_status[ST_TX_BUSY]              = tx_busy | r_tx_pend;
    w_status[ST_TX_PEND]              = r_tx_pend;
    w_status[ST_RX_OVF]               = r_rx_ovf;
    w_status[ST_RX_LVL+2:ST_RX_LVL]   = w_rx_level;
  end

  always_comb begin
    w_rdata = '0;
    case (w_off)
      DEC_WD'(OFF_CTRL):   w_rdata = {13'd0, r_ctrl};
      DEC_WD'(OFF_STATUS): w_rdata = w_status;
      DEC_WD'(OFF_BAUD):   w_rdata = r_baud;
      DEC_WD'(OFF_TXDATA): w_rdata = {8'd0, r_tx_hold};
      DEC_WD'(OFF_RXDATA): w_rdata = {8'd0, w_rx_dout};
      default:             w_rdata = '0;
    endcase
  end

  assign per_dout = w_sel ? w_rdata : 16'd0;

  assign irq = (r_ctrl.rxie & ~w_rx_empty)
             | (r_ctrl.txie & ~r_tx_pend & ~tx_busy)
             | (r_ctrl.rxie & r_rx_ovf);

endmodule

// File: tb/tb_uart_per_regs.sv
// -----------------------------------------------------------------------------
// tb_uart_per_regs
// Directed bench for uart_per_regs. Expected receive-queue values adapt to the
// UART_RX_FIFO_EN build option (depth 4 when defined, depth 1 otherwise).
// -----------------------------------------------------------------------------
module tb_uart_per_regs;

`ifdef UART_RX_FIFO_EN
  localparam int D = 4;
`else
  localparam int D = 1;
`endif

  logic        mclk = 1'b0;
  logic        puc_rst;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic        per_en;
  logic [1:0]  per_we;
  logic [15:0] per_dout;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [15:0] baud_div;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;

  always #5 mclk = ~mclk;

  uart_per_regs dut (
    .mclk     (mclk),
    .puc_rst  (puc_rst),
    .per_addr (per_addr),
    .per_din  (per_din),
    .per_en   (per_en),
    .per_we   (per_we),
    .per_dout (per_dout),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_busy  (tx_busy),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .baud_div (baud_div),
    .irq      (irq)
  );

  function automatic logic [13:0] wa(input logic [7:0] off);
    return 14'h0040 + 14'(off >> 1);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [13:0] a, output logic [15:0] d);
    @(negedge mclk);
    per_addr = a; per_en = 1'b1; per_we = 2'b00;
    #1 d = per_dout;
    @(posedge mclk); #1;
    per_en = 1'b0;
  endtask

  task automatic wr(input logic [13:0] a, input logic [1:0] we, input logic [15:0] v);
    @(negedge mclk);
    per_addr = a; per_en = 1'b1; per_we = we; per_din = v;
    @(posedge mclk); #1;
    per_en = 1'b0; per_we = 2'b00;
  endtask

  task automatic rxpush(input logic [7:0] b);
    @(negedge mclk);
    rx_data = b; rx_valid = 1'b1;
    @(posedge mclk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic rd_push(input logic [13:0] a, input logic [7:0] b, output logic [15:0] d);
    @(negedge mclk);
    per_addr = a; per_en = 1'b1; per_we = 2'b00;
    rx_data = b; rx_valid = 1'b1;
    #1 d = per_dout;
    @(posedge mclk); #1;
    per_en = 1'b0; rx_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] d;
    puc_rst = 1'b1; per_addr = '0; per_din = '0; per_en = 1'b0; per_we = 2'b00;
    tx_busy = 1'b0; rx_data = '0; rx_valid = 1'b0;
    repeat (3) @(posedge mclk);
    @(negedge mclk); puc_rst = 1'b0;

    // Reset state
    chk("rst_irq", 16'(irq), 16'h0000);
    chk("rst_tx_start", 16'(tx_start), 16'h0000);
    chk("rst_tx_data", 16'(tx_data), 16'h0000);
    chk("rst_baud_div", baud_div, 16'h1458);
    chk("rst_dout_idle", per_dout, 16'h0000);
    rd(wa(8'h0), d); chk("rst_ctrl", d, 16'h0000);
    rd(wa(8'h2), d); chk("rst_status", d, 16'h0000);
    rd(wa(8'h4), d); chk("rst_baud", d, 16'h1458);
    rd(wa(8'h6), d); chk("rst_txdata", d, 16'h0000);
    rd(wa(8'h8), d); chk("rst_rxdata", d, 16'h0000);
    rd(wa(8'hA), d); chk("rd_off_a", d, 16'h0000);

    // Transmit launch
    wr(wa(8'h0), 2'b11, 16'h0001);
    rd(wa(8'h0), d); chk("ctrl_en", d, 16'h0001);
    wr(wa(8'h6), 2'b01, 16'h0055);
    chk("tx_start_n1", 16'(tx_start), 16'h0001);
    chk("tx_data_n1", 16'(tx_data), 16'h0055);
    rd(wa(8'h2), d); chk("status_pend", d, 16'h0006);
    tx_busy = 1'b1;
    chk("tx_start_once", 16'(tx_start), 16'h0000);
    wr(wa(8'h6), 2'b01, 16'h0077);
    wr(wa(8'h6), 2'b01, 16'h00AA);
    rd(wa(8'h6), d); chk("txdata_ignored", d, 16'h0077);
    rd(wa(8'h2), d); chk("status_busy_pend", d, 16'h0006);
    chk("no_launch_busy", 16'(tx_start), 16'h0000);
    tx_busy = 1'b0;
    #1;
    chk("launch_after_busy", 16'(tx_start), 16'h0001);
    chk("launch_data", 16'(tx_data), 16'h0077);
    @(posedge mclk); #1;
    chk("launch_done", 16'(tx_start), 16'h0000);
    wr(wa(8'h0), 2'b11, 16'h0005);
    chk("irq_txie", 16'(irq), 16'h0001);

    // Receive queue fill and overflow
    wr(wa(8'h0), 2'b11, 16'h0003);
    chk("irq_rx_empty", 16'(irq), 16'h0000);
    for (int i = 0; i <= D; i++) rxpush(8'(17 * (i + 1)));
    rd(wa(8'h2), d); chk("status_full_ovf", d, 16'((D << 4) | 9));
    chk("irq_rx_full", 16'(irq), 16'h0001);
    for (int i = 0; i < D; i++) begin
      rd(wa(8'h8), d); chk("rx_pop", d, 16'(17 * (i + 1)));
    end
    rd(wa(8'h8), d); chk("rx_pop_empty", d, 16'h0000);
    rd(wa(8'h2), d); chk("status_ovf_only", d, 16'h0008);
    chk("irq_ovf", 16'(irq), 16'h0001);

    // Full queue: push and pop in the same cycle
    for (int i = 0; i < D; i++) rxpush(8'(i + 1));
    rd_push(wa(8'h8), 8'h66, d); chk("rx_pop_push", d, 16'h0001);
    rd(wa(8'h2), d); chk("status_full_kept", d, 16'((D << 4) | 9));
    wr(wa(8'h2), 2'b01, 16'h0008);
    rd(wa(8'h2), d); chk("status_ovf_clr", d, 16'((D << 4) | 1));
    for (int i = 1; i < D; i++) begin
      rd(wa(8'h8), d); chk("rx_drain", d, 16'(i + 1));
    end
    rd(wa(8'h8), d); chk("rx_pushed_66", d, 16'h0066);
    rd(wa(8'h8), d); chk("rx_empty_again", d, 16'h0000);
    chk("irq_cleared", 16'(irq), 16'h0000);

    // Disabled: rx_valid ignored
    wr(wa(8'h0), 2'b11, 16'h0000);
    rxpush(8'h99);
    rd(wa(8'h2), d); chk("status_en0", d, 16'h0000);

    // Byte-lane write and out-of-window access
    wr(wa(8'h4), 2'b01, 16'h1234);
    rd(wa(8'h4), d); chk("baud_lane_lo", d, 16'h1434);
    chk("baud_div_lane", baud_div, 16'h1434);
    rd(wa(8'h10), d); chk("out_of_window_rd", d, 16'h0000);
    wr(wa(8'h10), 2'b11, 16'hFFFF);
    rd(wa(8'h0), d); chk("out_of_window_wr", d, 16'h0000);

    // Asynchronous reset while work is outstanding
    wr(wa(8'h0), 2'b11, 16'h0007);
    tx_busy = 1'b1;
    wr(wa(8'h6), 2'b01, 16'h005A);
    rxpush(8'h12);
    rd(wa(8'h2), d); chk("pre_rst_status", d, 16'h0017);
    chk("pre_rst_irq", 16'(irq), 16'h0001);
    @(posedge mclk); #3;
    per_addr = wa(8'h8); per_en = 1'b1; per_we = 2'b00;
    tx_busy = 1'b0;
    puc_rst = 1'b1;
    #1;
    chk("arst_tx_data", 16'(tx_data), 16'h0000);
    chk("arst_tx_start", 16'(tx_start), 16'h0000);
    chk("arst_baud_div", baud_div, 16'h1458);
    chk("arst_irq", 16'(irq), 16'h0000);
    chk("arst_rxdata", per_dout, 16'h0000);
    per_addr = wa(8'h2);
    #1;
    chk("arst_status", per_dout, 16'h0000);
    per_en = 1'b0;
    @(negedge mclk); puc_rst = 1'b0;
    rd(wa(8'h0), d); chk("post_rst_ctrl", d, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_per_regs.md
# uart_per_regs

Memory-mapped register front-end between the openMSP430 peripheral bus (per_addr/per_din/per_en/per_we/per_dout) and the UART core (speed select, rx, tx). It decodes a 16-byte window, holds the baud divisor, buffers one transmit byte with a start handshake, queues received bytes, and raises a level interrupt. It sits directly upstream of the UART transmitter and downstream of the UART receiver.

## Interface
- BASE_ADDR, 15'h0080, byte base address of the register window; must be 16-byte aligned.
- DEC_WD, 4, address decode width in bits (16-byte window).
- BAUD_RST, 16'd5208, reset value of the baud divisor.
- mclk  in  1  main system clock; all state on the rising edge.
- puc_rst  in  1  reset, asynchronous, active-high.
- per_addr  in  14  peripheral word address.
- per_din  in  16  write data.
- per_en  in  1  peripheral access enable.
- per_we  in  2  byte write enables; [0] selects the low byte, [1] the high byte.
- per_dout  out  16  read data; 0 when not selected.
- tx_data  out  8  byte presented to the transmitter.
- tx_start  out  1  one-cycle launch pulse.
- tx_busy  in  1  transmitter busy.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle pulse; rx_data is valid.
- baud_div  out  16  divisor to both speed-select instances.
- irq  out  1  level interrupt.

## Operation
- The block is selected when per_en is 1 and per_addr[13:DEC_WD-1] equals BASE_ADDR[14:DEC_WD]. The byte offset is {per_addr[DEC_WD-2:0],1'b0}.
- 0x0 CTRL (R/W): bit 0 EN, bit 1 RXIE, bit 2 TXIE. All other bits read 0.
- 0x2 STATUS: bit 0 RX_AVAIL, bit 1 TX_BUSY (tx_busy OR pending), bit 2 TX_PEND, bit 3 RX_OVF, bits 6:4 RX_LEVEL. Writing 1 to bit 3 clears RX_OVF; all other STATUS bits ignore writes.
- 0x4 BAUD (R/W, 16 bit): drives baud_div. Each byte lane is written by its own per_we bit.
- 0x6 TXDATA: a write with per_we[0]=1 while TX_PEND=0 loads the hold register and sets TX_PEND. A write while TX_PEND=1 is ignored. Reads return the hold register.
- 0x8 RXDATA: reads return the FIFO head in bits 7:0, or 0 when the FIFO is empty. A read (per_we=0) of a non-empty FIFO pops the head. Writes are ignored.
- Offsets 0xA–0xE read 0.
- TX launch: when EN=1, TX_PEND=1 and tx_busy=0, tx_start pulses for one cycle with tx_data equal to the hold register, and TX_PEND clears on the same edge. A TXDATA write in the launch cycle is ignored because TX_PEND is still 1.
- RX push: when EN=1 and rx_valid=1, rx_data is pushed if the FIFO is not full. If it is full, the byte is dropped and RX_OVF is set.
- RX push and pop in the same cycle: when full, both occur and RX_OVF is not set. When empty, the read returns 0 and the push is stored.
- EN=0: rx_valid is ignored and no launch occurs. FIFO, hold register and TX_PEND are retained.
- irq = (RXIE & RX_AVAIL) | (TXIE & ~TX_PEND & ~tx_busy) | (RXIE & RX_OVF).

## Timing
- per_dout is combinational from per_addr/per_en in the access cycle, zero-masked when not selected.
- Register writes and RXDATA pops take effect at the next mclk edge.
- From a TXDATA write (cycle N) with tx_busy=0 and EN=1, tx_start is high in cycle N+1.
- From rx_valid (cycle N), RX_AVAIL is 1 from cycle N+1.
- Reset values: per_dout 0, tx_start 0, tx_data 0x00, baud_div BAUD_RST, irq 0, CTRL 0, FIFO empty, TX_PEND 0, RX_OVF 0.
- Reset asserted mid-transfer clears all state immediately, without waiting for a clock.

## Configuration
- UART_RX_FIFO_EN defined: the RX queue is a 4-entry circular FIFO with 2-bit read/write pointers that wrap; RX_LEVEL ranges 0–4.
- UART_RX_FIFO_EN undefined: the RX queue is a single holding register (depth 1); RX_LEVEL is 0 or 1 and all full/overflow rules apply at depth 1.

## Structure
- Shared package uart_pkg holds the register offsets, the CTRL/STATUS bit positions and the BAUD_RST default.
- One sub-module, uart_rx_fifo (parameter DEPTH), provides push, pop, full, empty and level outputs.

## Test plan
- Reset, then read all offsets -> CTRL=0x0000, STATUS=0x0000, BAUD=0x1458 (5208), RXDATA=0x0000; irq=0.
- Write CTRL=0x0001, write TXDATA=0x55 with tx_busy=0 -> tx_start high exactly 1 cycle later with tx_data=0x55; write 0xAA while tx_busy=1 and TX_PEND=1 -> ignored.
- EN=1, RXIE=1, pulse rx_valid with 0x11, 0x22, 0x33, 0x44, 0x55 -> RX_LEVEL=4, RX_OVF=1, irq=1; reads return 0x11, 0x22, 0x33, 0x44, then 0x00.
- FIFO full, rx_valid=0x66 in the same cycle as an RXDATA read -> read returns head, level stays 4, RX_OVF unchanged; write STATUS=0x0008 -> RX_OVF=0.
- Byte write BAUD with per_we=2'b01, data 0x1234 -> BAUD=0x1434; access at BASE_ADDR+0x10 -> per_dout=0, no state change.
- Assert puc_rst asynchronously while TX_PEND=1 and the FIFO holds data -> all outputs are at reset values before the next mclk edge.
